// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The loader takes the slave side; the host/bench takes the master side.
// Status levels (cpu_hold/done/error) travel with the bus for convenience.
interface imem_loader_if #(
  parameter int AW = 13
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: MAGIC, 16-bit big-endian word count, big-endian words, XOR checksum.
// Latency: 4th byte of a word -> imem_we next cycle; checksum byte -> done/error next cycle.
// Backpressure: rx_ready drops only in the imem_we cycle; nothing advances without pulse_en.
// Optional macro LOADER_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYCLES pulse_en ticks -> ERR.
module imem_loader #(
  parameter int         DEPTH          = 8192,
  parameter int         AW             = 13,
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         pulse_en,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   count;
  logic [AW-1:0] index;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [23:0]   shift;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;

  logic          accept;
  logic [7:0]    b;
  logic [15:0]   len_val;
  logic          last_word;
  logic          tmo_hit;

  // Reject configurations where the address cannot reach every word or the timeout is empty.
  if (TIMEOUT_CYCLES < 1 || (1 << AW) < DEPTH) begin : g_bad_cfg
    $error("imem_loader: bad DEPTH/AW/TIMEOUT_CYCLES combination");
  end

  assign b         = bus.rx_data;
  assign accept    = pulse_en & bus.rx_valid & ~we_q;
  assign len_val   = {count[15:8], b};
  assign last_word = (32'(index) == 32'(count) - 32'd1);

  assign bus.rx_ready   = ~we_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        in_frame;

  assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
  assign tmo_hit  = in_frame & pulse_en & ~accept &
                    (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Count idle ticks while a frame is open; any accepted byte or leaving the frame clears it.
  always_ff @(posedge clk) begin
    if (!clr)                     tmo_cnt <= '0;
    else if (!in_frame || accept) tmo_cnt <= '0;
    else if (pulse_en)            tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: advance on accepted bytes; MAGIC restarts only from the resting states.
  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = S_ERR;
    end else if (accept) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (b == MAGIC) state_nxt = S_LEN_HI;
        S_LEN_HI:              state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if ({1'b0, len_val} > 17'(DEPTH)) state_nxt = S_ERR;
          else if (len_val == 16'd0)        state_nxt = S_CSUM;
          else                              state_nxt = S_DATA;
        end
        S_DATA:  if (byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
        S_CSUM:  state_nxt = (b == csum) ? S_DONE : S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status levels are pure functions of state, so they change on the edge that enters it.
  always_comb begin
    bus.done     = 1'b0;
    bus.error    = 1'b0;
    bus.cpu_hold = 1'b1;
    case (state)
      S_IDLE:  bus.cpu_hold = 1'b0;
      S_DONE:  begin bus.done = 1'b1; bus.cpu_hold = 1'b0; end
      S_ERR:   bus.error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, word assembly, checksum and the single-cycle write strobe.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count    <= '0;
      index    <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      shift    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_HI: count[15:8] <= b;
          S_LEN_LO: begin
            count[7:0] <= b;
            index      <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
          end
          S_DATA: begin
            csum     <= csum ^ b;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], b};
            if (byte_cnt == 2'd3) begin
              we_q    <= 1'b1;
              waddr_q <= index;
              wdata_q <= {shift, b};
              index   <= index + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from word lists, expected writes are
// queued at send time and a negedge monitor pops/compares every imem_we pulse.
// Status levels are checked the cycle after the closing byte of each frame.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 8192;
  localparam int AW    = 13;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic clr;
  logic pulse_en;

  imem_loader_if #(.AW(AW)) bus();

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .pulse_en(pulse_en), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   frame_words[$];
  bit pulse_rand = 1'b0;
  bit gaps       = 1'b0;
  bit exp_done_lvl, exp_err_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic status(input string name, input bit d, input bit e, input bit h);
    check({name, ".done"},     32'(bus.done),     32'(d));
    check({name, ".error"},    32'(bus.error),    32'(e));
    check({name, ".cpu_hold"}, 32'(bus.cpu_hold), 32'(h));
    exp_done_lvl = d;
    exp_err_lvl  = e;
  endtask

  task automatic reset_values(input string name);
    status(name, 1'b0, 1'b0, 1'b0);
    check({name, ".rx_ready"},   32'(bus.rx_ready),   32'd1);
    check({name, ".imem_we"},    32'(bus.imem_we),    32'd0);
    check({name, ".imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({name, ".imem_wdata"}, bus.imem_wdata,      32'd0);
  endtask

  // pulse_en changes just after posedge so the driver's negedge sample is stable.
  initial begin
    pulse_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      pulse_en = pulse_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.imem_we === 1'b1) begin
        check("rx_ready_in_we", 32'(bus.rx_ready), 32'd0);
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                   bus.imem_waddr, bus.imem_wdata);
        end else begin
          check("waddr", 32'(bus.imem_waddr), 32'(exp_addr.pop_front()));
          check("wdata", bus.imem_wdata, exp_data.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] val);
    bit acc = 1'b0;
    bus.rx_data  = val;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = pulse_en && (bus.rx_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %0h not taken within 200 cycles, required acceptance", val);
    end
  endtask

  task automatic gap();
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    exp_addr.push_back(a);
    exp_data.push_back(w);
    for (int k = 3; k >= 0; k--) begin
      gap();
      send_byte(w[8*k +: 8]);
    end
  endtask

  // Everything after the MAGIC byte; words come from frame_words, padded with random ones.
  task automatic send_body(input logic [15:0] cnt, input bit good);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    send_byte(cnt[15:8]);
    gap();
    send_byte(cnt[7:0]);
    if (int'(cnt) > DEPTH) begin
      status("oversize", 1'b0, 1'b1, 1'b1);
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      w = (i < frame_words.size()) ? frame_words[i] : $urandom;
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(w, AW'(i));
    end
    gap();
    send_byte(good ? cs : (cs ^ 8'($urandom_range(1, 255))));
    if (good) status("frame_ok", 1'b1, 1'b0, 1'b0);
    else      status("frame_bad", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] cnt, input bit good);
    send_byte(8'hA5);
    gap();
    send_body(cnt, good);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  junk;
    clr          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    reset_values("reset");

    // Noise before MAGIC is dropped, then a zero-length frame.
    send_byte(8'h11);
    send_byte(8'h22);
    status("idle_noise", 1'b0, 1'b0, 1'b0);
    frame_words = {};
    send_frame(16'd0, 1'b1);

    // Two-word image.
    frame_words = {32'hDEADBEEF, 32'h01020304};
    send_frame(16'd2, 1'b1);

    // Same image, wrong checksum; a MAGIC then clears error on its edge.
    send_frame(16'd2, 1'b0);
    send_byte(8'hA5);
    status("restart", 1'b0, 1'b0, 1'b1);
    frame_words = {32'hA5A5A5A5};
    send_body(16'd1, 1'b1);

    // Count of DEPTH+1 is rejected with no writes.
    frame_words = {};
    send_frame(16'h2001, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of the data phase.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word($urandom, AW'(0));
    send_byte(8'h12);
    send_byte(8'h34);
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    reset_values("mid_clr");
    send_frame(16'd2, 1'b1);

    // Stall after the high count byte.
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (TMO + 4) @(posedge clk);
    #1;
`ifdef LOADER_TIMEOUT_EN
    status("timeout", 1'b0, 1'b1, 1'b1);
`else
    status("stall", 1'b0, 1'b0, 1'b1);
    send_byte(8'h01);
    w = $urandom;
    send_word(w, AW'(0));
    send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
    status("stall_resume", 1'b1, 1'b0, 1'b0);
`endif

    // Random frames with random pulse_en and gaps; a junk byte after each must not disturb status.
    for (int f = 0; f < 25; f++) begin
      pulse_rand  = ($urandom_range(0, 1) == 1);
      gaps        = ($urandom_range(0, 1) == 1);
      frame_words = {};
      if ($urandom_range(0, 3) == 0) frame_words.push_back(32'hA5A5A5A5);
      send_frame(16'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0));
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk);
      status("junk_after", exp_done_lvl, exp_err_lvl, exp_err_lvl);
    end

    // Largest accepted image.
    pulse_rand  = 1'b0;
    gaps        = 1'b0;
    frame_words = {};
    send_frame(16'(DEPTH), 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_addr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
